// File: rtl/branch_resolver_if.sv
// Decode/EX/feedback bundle for branch_resolver.
// BRANCH_RESOLVER_STATS_EN adds the statistics counters to the bundle.
interface branch_resolver_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
);
  logic                        i_dec_valid;
  logic                        i_dec_is_jump;
  logic [ADDR_WIDTH-1:0]       i_dec_pc;
  logic                        i_dec_prediction;
  logic [ADDR_WIDTH-1:0]       i_dec_recovery_target;
  logic                        o_full;
  logic                        i_ex_valid;
  logic                        i_ex_outcome;
  logic                        i_flush;
  logic                        o_fb_valid;
  logic [ADDR_WIDTH-1:0]       o_fb_pc;
  logic                        o_fb_prediction;
  logic                        o_fb_outcome;
  logic                        o_redirect_valid;
  logic [ADDR_WIDTH-1:0]       o_redirect_pc;
  logic [$clog2(DEPTH):0]      o_count;
  logic                        o_err;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0]                 o_stat_branches;
  logic [31:0]                 o_stat_mispredicts;

  modport master (
    output i_dec_valid, i_dec_is_jump, i_dec_pc, i_dec_prediction, i_dec_recovery_target,
           i_ex_valid, i_ex_outcome, i_flush,
    input  o_full, o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
           o_redirect_valid, o_redirect_pc, o_count, o_err,
           o_stat_branches, o_stat_mispredicts
  );
  modport slave (
    input  i_dec_valid, i_dec_is_jump, i_dec_pc, i_dec_prediction, i_dec_recovery_target,
           i_ex_valid, i_ex_outcome, i_flush,
    output o_full, o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
           o_redirect_valid, o_redirect_pc, o_count, o_err,
           o_stat_branches, o_stat_mispredicts
  );
`else
  modport master (
    output i_dec_valid, i_dec_is_jump, i_dec_pc, i_dec_prediction, i_dec_recovery_target,
           i_ex_valid, i_ex_outcome, i_flush,
    input  o_full, o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
           o_redirect_valid, o_redirect_pc, o_count, o_err
  );
  modport slave (
    input  i_dec_valid, i_dec_is_jump, i_dec_pc, i_dec_prediction, i_dec_recovery_target,
           i_ex_valid, i_ex_outcome, i_flush,
    output o_full, o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
           o_redirect_valid, o_redirect_pc, o_count, o_err
  );
`endif
endinterface

// File: rtl/branch_resolver.sv
// In-order tracker of predicted branches; resolves the oldest against EX and emits feedback/redirect.
// Optional macro BRANCH_RESOLVER_STATS_EN adds saturating branch/mispredict counters.
module branch_resolver #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic             clk,
  input logic             rst,
  branch_resolver_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred;
    logic [ADDR_WIDTH-1:0] rtgt;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head_e;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            full, pop, mispredict_now, push;

  assign full           = (count == CW'(DEPTH));
  assign head_e         = mem[head];
  assign pop            = bus.i_ex_valid & (count != '0);
  assign mispredict_now = pop & (bus.i_ex_outcome != head_e.pred);
  // A full queue still takes a push when a correct pop frees the head slot this cycle.
  assign push = bus.i_dec_valid & ~bus.i_dec_is_jump & ~bus.i_flush & ~mispredict_now
              & (~full | pop);

  assign bus.o_full  = full;
  assign bus.o_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{pc: bus.i_dec_pc, pred: bus.i_dec_prediction,
                             rtgt: bus.i_dec_recovery_target};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head                 <= '0;
      tail                 <= '0;
      count                <= '0;
      bus.o_fb_valid       <= 1'b0;
      bus.o_fb_pc          <= '0;
      bus.o_fb_prediction  <= 1'b0;
      bus.o_fb_outcome     <= 1'b0;
      bus.o_redirect_valid <= 1'b0;
      bus.o_redirect_pc    <= '0;
      bus.o_err            <= 1'b0;
    end else begin
      bus.o_fb_valid       <= pop;
      bus.o_redirect_valid <= mispredict_now;
      if (pop) begin
        bus.o_fb_pc         <= head_e.pc;
        bus.o_fb_prediction <= head_e.pred;
        bus.o_fb_outcome    <= bus.i_ex_outcome;
      end
      if (mispredict_now) bus.o_redirect_pc <= head_e.rtgt;
      if (bus.i_ex_valid && count == '0) bus.o_err <= 1'b1;
      if (push) tail <= tail + PW'(1);
      // Push is already suppressed on mispredict/flush, so tail is stable and head can snap to it.
      if (mispredict_now || bus.i_flush) begin
        head  <= tail;
        count <= '0;
      end else begin
        if (pop) head <= head + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_stat_branches    <= '0;
      bus.o_stat_mispredicts <= '0;
    end else begin
      if (pop && bus.o_stat_branches != 32'hFFFF_FFFF)
        bus.o_stat_branches <= bus.o_stat_branches + 32'd1;
      if (mispredict_now && bus.o_stat_mispredicts != 32'hFFFF_FFFF)
        bus.o_stat_mispredicts <= bus.o_stat_mispredicts + 32'd1;
    end
  end
`endif
endmodule
